// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr initiator toward the CSR register file.
// Each accepted instruction runs ISSUE -> CAPTURE -> WRITE as a
// read-modify-write. The write strobe and the response are registered on
// the edge that leaves WRITE, so they appear in the cycle after that edge.
module csr_access_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rd_idx,
  input  logic            freeze,
  output logic [11:0]     csr_adr_rd,
  input  logic [XLEN-1:0] csr_rddata,
  output logic [11:0]     csr_adr_wr,
  output logic [XLEN-1:0] csr_wrdata,
  output logic            csr_wr_en,
  output logic            rsp_valid,
  output logic            rsp_rd_wr_en,
  output logic [4:0]      rsp_rd_idx,
  output logic [XLEN-1:0] rsp_rd_data,
  output logic            rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched instruction context
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic [4:0]      rd_idx_q;
  logic            illegal_q;
  logic            wr_intent_q;

  // Captured old value and computed new value
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_q;

  // Registered outputs
  logic            csr_wr_en_q;
  logic [11:0]     csr_adr_wr_q;
  logic [XLEN-1:0] csr_wrdata_q;
  logic            rsp_valid_q;
  logic            rsp_rd_wr_en_q;
  logic [4:0]      rsp_rd_idx_q;
  logic [XLEN-1:0] rsp_rd_data_q;
  logic            rsp_illegal_q;

  // FSM control strobes
  logic accept;
  logic capture;
  logic finish;

  // Request decode
  logic [XLEN-1:0] dec_src;
  logic            dec_wr_intent;
  logic            dec_illegal;

  // Modify result
  logic [XLEN-1:0] new_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!freeze) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode source operand, write intent and legality of the incoming request
  always_comb begin
    dec_src       = req_funct3[2] ? XLEN'(req_rs1_idx) : req_rs1_data;
    dec_wr_intent = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
    dec_illegal   = (req_funct3[1:0] == 2'b00) ||
                    (RO_CHECK && (req_addr[11:10] == 2'b11) && dec_wr_intent);
  end

  // Compute the new CSR value from the freshly returned read data
  always_comb begin
    new_val = csr_rddata;
    case (op_q)
      2'b01:   new_val = src_q;
      2'b10:   new_val = csr_rddata | src_q;
      2'b11:   new_val = csr_rddata & ~src_q;
      default: new_val = csr_rddata;
    endcase
  end

  // Instruction context, captured data and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= '0;
      addr_q         <= '0;
      src_q          <= '0;
      rd_idx_q       <= '0;
      illegal_q      <= 1'b0;
      wr_intent_q    <= 1'b0;
      old_q          <= '0;
      new_q          <= '0;
      csr_wr_en_q    <= 1'b0;
      csr_adr_wr_q   <= '0;
      csr_wrdata_q   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rd_wr_en_q <= 1'b0;
      rsp_rd_idx_q   <= '0;
      rsp_rd_data_q  <= '0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      csr_wr_en_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rd_wr_en_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;

      if (accept) begin
        op_q        <= req_funct3[1:0];
        addr_q      <= req_addr;
        src_q       <= dec_src;
        rd_idx_q    <= req_rd_idx;
        illegal_q   <= dec_illegal;
        wr_intent_q <= dec_wr_intent;
      end

      if (capture) begin
        old_q <= csr_rddata;
        new_q <= new_val;
      end

      if (finish) begin
        rsp_valid_q    <= 1'b1;
        rsp_rd_data_q  <= old_q;
        rsp_rd_idx_q   <= rd_idx_q;
        rsp_illegal_q  <= illegal_q;
        rsp_rd_wr_en_q <= !illegal_q && (rd_idx_q != 5'd0);
        if (!illegal_q && wr_intent_q) begin
          csr_wr_en_q  <= 1'b1;
          csr_adr_wr_q <= addr_q;
          csr_wrdata_q <= new_q;
        end
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign csr_adr_rd   = addr_q;
  assign csr_adr_wr   = csr_adr_wr_q;
  assign csr_wrdata   = csr_wrdata_q;
  assign csr_wr_en    = csr_wr_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rd_wr_en = rsp_rd_wr_en_q;
  assign rsp_rd_idx   = rsp_rd_idx_q;
  assign rsp_rd_data  = rsp_rd_data_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: drives Zicsr requests against csr_access_unit with a
// behavioural CSR file attached, and compares every cycle against an
// instruction-level reference model holding the expected CSR contents.
module tb_csr_access_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_rs1_data;
  logic [4:0]      req_rs1_idx;
  logic [4:0]      req_rd_idx;
  logic            freeze;
  logic [11:0]     csr_adr_rd;
  logic [XLEN-1:0] csr_rddata;
  logic [11:0]     csr_adr_wr;
  logic [XLEN-1:0] csr_wrdata;
  logic            csr_wr_en;
  logic            rsp_valid;
  logic            rsp_rd_wr_en;
  logic [4:0]      rsp_rd_idx;
  logic [XLEN-1:0] rsp_rd_data;
  logic            rsp_illegal;

  // Environment CSR file and its preload port
  logic [31:0] csr_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  // Reference model state: expected CSR contents
  logic [31:0] ref_csr [0:4095];
  logic [11:0] addr_tab [6] = '{12'h340, 12'h341, 12'h300, 12'hC00, 12'hF14, 12'h7C0};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  csr_access_unit #(
    .XLEN    (XLEN),
    .RO_CHECK(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_rs1_data(req_rs1_data),
    .req_rs1_idx (req_rs1_idx),
    .req_rd_idx  (req_rd_idx),
    .freeze      (freeze),
    .csr_adr_rd  (csr_adr_rd),
    .csr_rddata  (csr_rddata),
    .csr_adr_wr  (csr_adr_wr),
    .csr_wrdata  (csr_wrdata),
    .csr_wr_en   (csr_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_rd_wr_en(rsp_rd_wr_en),
    .rsp_rd_idx  (rsp_rd_idx),
    .rsp_rd_data (rsp_rd_data),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: registered read that holds under freeze, single-cycle write
  always @(posedge clk) begin
    if (!freeze) csr_rddata <= csr_mem[csr_adr_rd];
    if (csr_wr_en) csr_mem[csr_adr_wr] <= csr_wrdata;
    if (pre_en) csr_mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en     = 1'b0;
    ref_csr[a] = d;
  endtask

  // One instruction: k freeze cycles while in ISSUE, then random freeze later.
  // Called at a negedge with the unit idle; returns at a negedge.
  task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] data, input logic [4:0] idx,
                         input logic [4:0] rd, input int k);
    logic [31:0] src, old, nv;
    logic        writes, illegal, do_wr, rdwe;
    int          lat;
    // Instruction semantics
    src     = f3[2] ? {27'd0, idx} : data;
    old     = ref_csr[addr];
    writes  = (f3[1:0] == 2'b01) ? 1'b1 : (idx != 5'd0);
    illegal = (f3 == 3'b000) || (f3 == 3'b100) || (addr[11:10] == 2'b11 && writes);
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    do_wr = !illegal && writes;
    rdwe  = !illegal && (rd != 5'd0);
    lat   = k + 3;

    check("req_ready_at_accept", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = addr;
    req_rs1_data = data;
    req_rs1_idx  = idx;
    req_rd_idx   = rd;
    freeze       = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid    = 1'b0;
        req_funct3   = 3'($urandom);
        req_addr     = 12'($urandom);
        req_rs1_data = $urandom;
        req_rs1_idx  = 5'($urandom);
        req_rd_idx   = 5'($urandom);
      end
      check("req_ready",   32'(req_ready),   32'(c == lat));
      check("rsp_valid",   32'(rsp_valid),   32'(c == lat));
      check("csr_wr_en",   32'(csr_wr_en),   32'((c == lat) && do_wr));
      check("rsp_illegal", 32'(rsp_illegal), 32'((c == lat) && illegal));
      check("csr_adr_rd",  32'(csr_adr_rd),  32'(addr));
      if (c == lat) begin
        check("rsp_rd_data",  rsp_rd_data,         old);
        check("rsp_rd_idx",   32'(rsp_rd_idx),     32'(rd));
        check("rsp_rd_wr_en", 32'(rsp_rd_wr_en),   32'(rdwe));
        if (do_wr) begin
          check("csr_adr_wr", 32'(csr_adr_wr), 32'(addr));
          check("csr_wrdata", csr_wrdata,      nv);
        end
      end else begin
        if (c + 1 <= k)      freeze = 1'b1;
        else if (c + 1 == k + 1) freeze = 1'b0;
        else                 freeze = 1'($urandom);
        @(posedge clk);
      end
    end
    freeze = 1'b0;
    if (do_wr) ref_csr[addr] = nv;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_funct3   = '0;
    req_addr     = '0;
    req_rs1_data = '0;
    req_rs1_idx  = '0;
    req_rd_idx   = '0;
    freeze       = 1'b0;
    pre_en       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",    32'(req_ready),    32'd1);
    check("rst_csr_wr_en",    32'(csr_wr_en),    32'd0);
    check("rst_rsp_valid",    32'(rsp_valid),    32'd0);
    check("rst_rsp_illegal",  32'(rsp_illegal),  32'd0);
    check("rst_rsp_rd_wr_en", 32'(rsp_rd_wr_en), 32'd0);
    check("rst_csr_adr_rd",   32'(csr_adr_rd),   32'd0);
    check("rst_csr_adr_wr",   32'(csr_adr_wr),   32'd0);
    check("rst_csr_wrdata",   csr_wrdata,        32'd0);
    check("rst_rsp_rd_data",  rsp_rd_data,       32'd0);
    check("rst_rsp_rd_idx",   32'(rsp_rd_idx),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) preload(addr_tab[i], $urandom);
    preload(12'h340, 32'h0000_00F0);

    // Directed cases
    run_txn(3'b010, 12'h340, 32'h0000_000F, 5'd5, 5'd6, 0);  // CSRRS -> 0xFF
    run_txn(3'b011, 12'h340, 32'h0000_000F, 5'd5, 5'd0, 0);  // CSRRC -> 0xF0, rd=x0
    run_txn(3'b110, 12'h340, $urandom,      5'd0, 5'd7, 0);  // CSRRSI zimm=0
    run_txn(3'b001, 12'hF14, 32'h0000_CAFE, 5'd9, 5'd3, 0);  // RO write -> illegal
    run_txn(3'b010, 12'hF14, $urandom,      5'd0, 5'd3, 0);  // RO read -> legal
    run_txn(3'b001, 12'h340, 32'h0000_00A5, 5'd1, 5'd8, 3);  // freeze 3 in ISSUE

    // Reset while in CAPTURE aborts the sequence
    check("abort_req_ready", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_funct3   = 3'b001;
    req_addr     = 12'h340;
    req_rs1_data = 32'hDEAD_BEEF;
    req_rs1_idx  = 5'd3;
    req_rd_idx   = 5'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after_rst", 32'(req_ready), 32'd1);
    check("abort_wr_en",           32'(csr_wr_en), 32'd0);
    check("abort_rsp_valid",       32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_wr_en_later",     32'(csr_wr_en), 32'd0);
      check("abort_rsp_valid_later", 32'(rsp_valid), 32'd0);
    end

    // Back-to-back write then read of the same CSR
    run_txn(3'b101, 12'h340, $urandom, 5'd5, 5'd1, 0);       // CSRRWI zimm=5
    check("b2b_model_value", ref_csr[12'h340], 32'd5);
    run_txn(3'b010, 12'h340, $urandom, 5'd0, 5'd2, 0);       // CSRRS x0 -> old=5

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [4:0] idx, rd;
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 5)],
              $urandom, idx, rd, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
